// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB colour-cycle monitor.
// Lines are active-low and packed {R,G,B}.
package rgb_pkg;

   typedef enum logic [2:0] {
      RED     = 3'd0,
      YELLOW  = 3'd1,
      GREEN   = 3'd2,
      CYAN    = 3'd3,
      BLUE    = 3'd4,
      MAGENTA = 3'd5,
      NONE    = 3'd7
   } color_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      TRACK = 2'd2
   } mon_state_t;

   function automatic color_t decode_pattern(input logic [2:0] rgb);
      case (rgb)
         3'b011:  return RED;
         3'b001:  return YELLOW;
         3'b101:  return GREEN;
         3'b100:  return CYAN;
         3'b110:  return BLUE;
         3'b010:  return MAGENTA;
         default: return NONE;
      endcase
   endfunction

   function automatic color_t successor(input color_t c);
      case (c)
         RED:     return YELLOW;
         YELLOW:  return GREEN;
         GREEN:   return CYAN;
         CYAN:    return BLUE;
         BLUE:    return MAGENTA;
         MAGENTA: return RED;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/rgb_cycle_monitor_if.sv
// RGB line inputs and monitor status outputs; master drives the lines,
// slave is the monitor.
interface rgb_cycle_monitor_if #(parameter int DW = 21);
   logic          RGB_R;
   logic          RGB_G;
   logic          RGB_B;
   logic [2:0]    color;
   logic          color_valid;
   logic          color_change;
   logic          seq_error;
   logic          dwell_error;
   logic          locked;
   logic [DW-1:0] last_dwell;

   modport master (
      output RGB_R, RGB_G, RGB_B,
      input  color, color_valid, color_change, seq_error, dwell_error,
             locked, last_dwell
   );

   modport slave (
      input  RGB_R, RGB_G, RGB_B,
      output color, color_valid, color_change, seq_error, dwell_error,
             locked, last_dwell
   );
endinterface

// File: rtl/rgb_input_filter.sv
// Two-flop synchroniser per line followed by a stability filter; emits the
// accepted pattern and a one-cycle strobe whenever it changes.
module rgb_input_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] pins,
   output logic [2:0] pattern,
   output logic       accept
);

   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

   logic [2:0]    sync_p0;
   logic [2:0]    sync_p1;
   logic [2:0]    cand;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 3'b111;
         sync_p1 <= 3'b111;
         cand    <= 3'b111;
         cnt     <= '0;
         pattern <= 3'b111;
         accept  <= 1'b0;
      end else begin
         // synchroniser stage boundary: sync_p0 -> sync_p1
         sync_p0 <= pins;
         sync_p1 <= sync_p0;
         accept  <= 1'b0;
         if (sync_p1 != cand) begin
            cand <= sync_p1;
            cnt  <= '0;
         end else if (cnt != CMAX) begin
            cnt <= cnt + CW'(1);
         end
         // cand has been seen STABLE_CYCLES times in a row here
         if (cnt == CMAX && cand != pattern) begin
            pattern <= cand;
            accept  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rgb_cycle_monitor.sv
// Checks colour order and per-step dwell of an active-low RGB cycling source.
// FSM tracks IDLE -> FIRST -> TRACK; the dwell counter restarts on each accept.
module rgb_cycle_monitor
   import rgb_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int DWELL_NOM     = 2000000,
   parameter int DWELL_TOL     = 16
) (
   input logic                 clk,
   input logic                 reset,
   rgb_cycle_monitor_if.slave  mon
);

   localparam int            DW     = $clog2(DWELL_NOM + DWELL_TOL + 2);
   localparam int            DMAX_I = DWELL_NOM + DWELL_TOL + 1;
   localparam logic [DW-1:0] DMAX   = DW'(DMAX_I);

   logic [2:0]    pattern;
   logic          accept;

   mon_state_t    state, state_nxt;
   logic [DW-1:0] dcnt;
   logic [DW-1:0] last_q;
   color_t        color_q, color_nxt;
   logic          valid_q, valid_nxt;
   logic          change_q, change_nxt;
   logic          seqe_q, seqe_nxt;
   logic          dwe_q, dwe_nxt;

   color_t        new_col;
   logic          new_ok;
   logic          is_succ;
   logic          dwell_bad;
   logic          stall;

   rgb_input_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .clk     (clk),
      .reset   (reset),
      .pins    ({mon.RGB_R, mon.RGB_G, mon.RGB_B}),
      .pattern (pattern),
      .accept  (accept)
   );

   assign new_col   = decode_pattern(pattern);
   assign new_ok    = (new_col != NONE);
   assign is_succ   = new_ok && (new_col == successor(color_q));
   assign dwell_bad = (int'(dcnt) > DWELL_NOM + DWELL_TOL) ||
                      (int'(dcnt) < DWELL_NOM - DWELL_TOL);
   // an accept restarts the counter, so a stall can only fire without one
   assign stall     = (state == TRACK) && (dcnt == DMAX) && !accept;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         case (state)
            IDLE:        if (new_ok) state_nxt = FIRST;
            FIRST,
            TRACK: begin
               if (!new_ok)      state_nxt = IDLE;
               else if (is_succ) state_nxt = TRACK;
               else              state_nxt = FIRST;
            end
            default:     state_nxt = IDLE;
         endcase
      end else if (stall) begin
         state_nxt = FIRST;
      end
   end

   always_comb begin
      color_nxt  = color_q;
      valid_nxt  = valid_q;
      change_nxt = 1'b0;
      seqe_nxt   = 1'b0;
      dwe_nxt    = 1'b0;
      if (accept) begin
         if (new_ok) begin
            color_nxt = new_col;
            valid_nxt = 1'b1;
            if (state != IDLE) begin
               if (is_succ) begin
                  change_nxt = 1'b1;
                  dwe_nxt    = (state == TRACK) && dwell_bad;
               end else begin
                  seqe_nxt = 1'b1;
               end
            end
         end else begin
            color_nxt = NONE;
            valid_nxt = 1'b0;
            seqe_nxt  = (state != IDLE);
         end
      end else if (stall) begin
         dwe_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         color_q  <= NONE;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         seqe_q   <= 1'b0;
         dwe_q    <= 1'b0;
         dcnt     <= '0;
         last_q   <= '0;
      end else begin
         color_q  <= color_nxt;
         valid_q  <= valid_nxt;
         change_q <= change_nxt;
         seqe_q   <= seqe_nxt;
         dwe_q    <= dwe_nxt;
         if (accept) begin
            last_q <= dcnt;
            dcnt   <= DW'(1);
         end else if (dcnt != DMAX) begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

   assign mon.color        = color_q;
   assign mon.color_valid  = valid_q;
   assign mon.color_change = change_q;
   assign mon.seq_error    = seqe_q;
   assign mon.dwell_error  = dwe_q;
   assign mon.locked       = (state == TRACK);
   assign mon.last_dwell   = last_q;

endmodule

// File: tb/tb_rgb_cycle_monitor.sv
// Directed scoreboard bench for rgb_cycle_monitor (STABLE_CYCLES=4,
// DWELL_NOM=100, DWELL_TOL=2).
module tb_rgb_cycle_monitor;

   localparam int STABLE_CYCLES = 4;
   localparam int DWELL_NOM     = 100;
   localparam int DWELL_TOL     = 2;
   localparam int DW            = $clog2(DWELL_NOM + DWELL_TOL + 2);

   localparam logic [2:0] P_R   = 3'b011;
   localparam logic [2:0] P_Y   = 3'b001;
   localparam logic [2:0] P_G   = 3'b101;
   localparam logic [2:0] P_C   = 3'b100;
   localparam logic [2:0] P_B   = 3'b110;
   localparam logic [2:0] P_M   = 3'b010;
   localparam logic [2:0] P_OFF = 3'b111;

   typedef struct {
      logic [2:0] color;
      logic       valid;
      logic       chg;
      logic       seq;
      logic       dwe;
      logic       lck;
      int         last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_chg = 0;
   int   n_seq = 0;
   int   n_dwe = 0;
   int   snap_chg, snap_seq, snap_dwe;
   logic [2:0] prev_col;
   exp_t sb[$];

   always #5 clk = ~clk;

   rgb_cycle_monitor_if #(.DW(DW)) bus ();

   rgb_cycle_monitor #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .DWELL_NOM     (DWELL_NOM),
      .DWELL_TOL     (DWELL_TOL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus)
   );

   always @(negedge clk) begin
      if (bus.color_change === 1'b1) n_chg++;
      if (bus.seq_error    === 1'b1) n_seq++;
      if (bus.dwell_error  === 1'b1) n_dwe++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_pat(input logic [2:0] p);
      bus.RGB_R = p[2];
      bus.RGB_G = p[1];
      bus.RGB_B = p[0];
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".color"},  bus.color, 7);
      check({tag, ".valid"},  bus.color_valid, 0);
      check({tag, ".pulses"}, {bus.color_change, bus.seq_error, bus.dwell_error}, 0);
      check({tag, ".locked"}, bus.locked, 0);
      check({tag, ".last"},   bus.last_dwell, 0);
   endtask

   // Drive a pattern at a negedge; outputs must move exactly 7 edges later.
   // The task consumes `period` cycles in total so steps are period apart.
   task automatic step(input string tag, input logic [2:0] pat, input int period,
                       input logic [2:0] col, input logic vld, input logic chg,
                       input logic seq, input logic dwe, input logic lck,
                       input int last);
      exp_t e;
      e.color = col; e.valid = vld; e.chg = chg; e.seq = seq;
      e.dwe = dwe; e.lck = lck; e.last = last;
      drive_pat(pat);
      sb.push_back(e);
      repeat (7) @(negedge clk);
      check({tag, ".early_color"}, bus.color, prev_col);
      check({tag, ".early_pulse"}, {bus.color_change, bus.seq_error, bus.dwell_error}, 0);
      @(negedge clk);
      e = sb.pop_front();
      check({tag, ".color"},  bus.color, e.color);
      check({tag, ".valid"},  bus.color_valid, e.valid);
      check({tag, ".change"}, bus.color_change, e.chg);
      check({tag, ".seq"},    bus.seq_error, e.seq);
      check({tag, ".dwell"},  bus.dwell_error, e.dwe);
      check({tag, ".locked"}, bus.locked, e.lck);
      if (e.last >= 0) check({tag, ".last"}, bus.last_dwell, e.last);
      @(negedge clk);
      check({tag, ".pulse_clr"}, {bus.color_change, bus.seq_error, bus.dwell_error}, 0);
      prev_col = e.color;
      repeat (period - 9) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      drive_pat(P_OFF);
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (110) @(negedge clk);
      check("idle.color", bus.color, 7);
      prev_col = 3'd7;

      // full cycle including magenta -> red wrap
      step("red0", P_R, 100, 3'd0, 1, 0, 0, 0, 0, 103);
      step("yel",  P_Y, 100, 3'd1, 1, 1, 0, 0, 1, 100);
      step("grn",  P_G, 100, 3'd2, 1, 1, 0, 0, 1, 100);
      step("cyn",  P_C, 100, 3'd3, 1, 1, 0, 0, 1, 100);
      step("blu",  P_B, 100, 3'd4, 1, 1, 0, 0, 1, 100);
      step("mag",  P_M, 100, 3'd5, 1, 1, 0, 0, 1, 100);
      step("wrap", P_R, 9,   3'd0, 1, 1, 0, 0, 1, 100);
      check("cycle.n_chg", n_chg, 6);
      check("cycle.n_seq", n_seq, 0);
      check("cycle.n_dwe", n_dwe, 0);

      // three-cycle yellow glitch inside the red step
      repeat (11) @(negedge clk);
      snap_chg = n_chg; snap_seq = n_seq; snap_dwe = n_dwe;
      drive_pat(P_Y);
      repeat (3) @(negedge clk);
      drive_pat(P_R);
      repeat (10) @(negedge clk);
      check("glitch.color", bus.color, 0);
      check("glitch.valid", bus.color_valid, 1);
      check("glitch.pulses", n_chg + n_seq + n_dwe, snap_chg + snap_seq + snap_dwe);
      repeat (67) @(negedge clk);

      // illegal step, then dwell tolerance edges
      step("skip",  P_G, 50,  3'd2, 1, 0, 1, 0, 0, 100);
      step("nochk", P_C, 97,  3'd3, 1, 1, 0, 0, 1, 50);
      step("d97",   P_B, 98,  3'd4, 1, 1, 0, 1, 1, 97);
      step("d98",   P_M, 102, 3'd5, 1, 1, 0, 0, 1, 98);
      step("d102",  P_R, 103, 3'd0, 1, 1, 0, 0, 1, 102);
      step("d103",  P_Y, 9,   3'd1, 1, 1, 0, 1, 1, 103);

      // stall: counter hits 103 on the edge before the pulse
      snap_dwe = n_dwe;
      repeat (101) @(negedge clk);
      check("stall.pre_dwe", bus.dwell_error, 0);
      check("stall.pre_lock", bus.locked, 1);
      @(negedge clk);
      check("stall.dwe", bus.dwell_error, 1);
      check("stall.lock", bus.locked, 0);
      check("stall.color", bus.color, 1);
      @(negedge clk);
      check("stall.dwe_clr", bus.dwell_error, 0);
      repeat (150) @(negedge clk);
      check("stall.once", n_dwe, snap_dwe + 1);

      step("off",      P_OFF, 20, 3'd7, 0, 0, 1, 0, 0, 103);
      step("red_idle", P_R,   9,  3'd0, 1, 0, 0, 0, 0, 20);

      // reset mid-step
      repeat (21) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("midrst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      prev_col = 3'd7;
      step("rst_red", P_R, 9, 3'd0, 1, 0, 0, 0, 0, 7);
      step("rst_yel", P_Y, 9, 3'd1, 1, 1, 0, 0, 1, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_cycle_monitor.md
Name: rgb_cycle_monitor

Overview:
- Receive-side checker for the three active-low RGB LED lines produced by the colour-cycle generator.
- Synchronises and glitch-filters the lines, then decodes the pattern into a colour code.
- Verifies the red→yellow→green→cyan→blue→magenta→red order and checks the dwell time per colour.
- Used on the board loopback and in benches as the self-check for any RGB cycling block.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a pattern (≥2).
- DWELL_NOM, 2000000: nominal clock cycles per colour step.
- DWELL_TOL, 16: allowed ± deviation from DWELL_NOM.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- RGB_R  in  1  red line, active-low (0 = lit), asynchronous to clk
- RGB_G  in  1  green line, active-low
- RGB_B  in  1  blue line, active-low
- color  out  3  decoded colour: 0 red, 1 yellow, 2 green, 3 cyan, 4 blue, 5 magenta, 7 none/invalid
- color_valid  out  1  accepted pattern is a legal colour
- color_change  out  1  one-cycle pulse on a legal successor step
- seq_error  out  1  one-cycle pulse on an illegal step or pattern
- dwell_error  out  1  one-cycle pulse on a dwell out of tolerance, or a stall
- locked  out  1  high in state TRACK
- last_dwell  out  DW  measured dwell of the last accepted change; DW = $clog2(DWELL_NOM+DWELL_TOL+2)

Behaviour:
- Reset (synchronous, wins over everything):
  - synchroniser flops, candidate and accepted pattern = 3'b111 (off).
  - color = 7, color_valid = 0, pulses = 0, locked = 0, last_dwell = 0, state IDLE, dwell counter = 0.
- Pattern decode, as {R,G,B} active-low:
  - 011 red, 001 yellow, 101 green, 100 cyan, 110 blue, 010 magenta.
  - 111 (off) and 000 (white) are invalid and decode to 7.
- Synchroniser: two flops per line.
- Filter:
  - If the synchronised pattern differs from the candidate, load the candidate and clear the stability count.
  - Otherwise increment the count, saturating at STABLE_CYCLES-1.
  - When count == STABLE_CYCLES-1 and candidate != accepted, load accepted. This is the accept event.
- Latency: color updates on rising edge STABLE_CYCLES+3 after the edge that first samples the new pin value. Pulses are asserted in that same cycle.
- Any pattern held for fewer than STABLE_CYCLES synchronised samples is ignored.
- Dwell counter:
  - Set to 1 on each accept event; otherwise increments, saturating at DWELL_NOM+DWELL_TOL+1.
  - At an accept event, the pre-update value is the dwell and is loaded into last_dwell.
- FSM states IDLE, FIRST, TRACK, evaluated on each accept event:
  - Valid colour, IDLE → FIRST. No pulse.
  - Valid successor, FIRST → TRACK. color_change pulse, no dwell check.
  - Valid successor, in TRACK → stay in TRACK. color_change pulse. dwell_error pulse if |dwell - DWELL_NOM| > DWELL_TOL.
  - Valid non-successor, from FIRST or TRACK → FIRST. seq_error pulse.
  - Invalid pattern, from FIRST or TRACK → IDLE. seq_error pulse, color = 7, color_valid = 0.
  - Invalid pattern, in IDLE → stay in IDLE. No pulse.
- Stall: in TRACK, when the dwell counter reaches DWELL_NOM+DWELL_TOL+1 with no accept event, pulse dwell_error once and go to FIRST.
- Successor is (c+1) mod 6. Magenta→red is legal.
- Accept and stall never coincide, because the counter restarts on accept.
- Reset asserted mid-step discards all history; the first post-reset colour lands in FIRST.

Decomposition:
- rgb_pkg holds:
  - color_t enum (RED..MAGENTA = 0..5, NONE = 7)
  - pattern-to-colour decode function
  - successor function
  - monitor state enum
- Sub-module rgb_input_filter: two-flop synchroniser plus stability filter. It outputs the accepted pattern and a one-cycle accept strobe.
- The top level holds the FSM, the dwell counter and the output registers.

Test Plan (STABLE_CYCLES=4, DWELL_NOM=100, DWELL_TOL=2):
- Reset, then drive 011 → color=0 and color_valid=1 exactly on edge 7 after sampling; locked=0; no pulses.
- Full cycle with one step every 100 cycles → color_change on every step; locked=1 from the second step; last_dwell=100; no errors through the magenta→red wrap.
- During red, drive yellow for 3 cycles then return to red → no change to color and no pulse.
- Step red→green → seq_error pulse, color=2, locked=0; next green→cyan gives color_change with no dwell check.
- In TRACK, step after 97 cycles → dwell_error; step after 98 or 102 cycles → no error; after 103 cycles → dwell_error.
- Hold one colour in TRACK → a single dwell_error when the counter reaches 103 and locked drops. Then drive 111 → seq_error, color=7, color_valid=0. Assert reset mid-step → all outputs return to reset values on the next edge.
